// File: rtl/id_stage.sv
// Decode/operand stage. Splits the IF instruction into fields, reads the GPR
// file, forwards EX/MEM results, resolves branches combinationally back to IF,
// interlocks on load-use hazards and registers the ID/EX bundle.
//
// Bundle handshake: every *_en_ is an active-low "bundle valid". There is no
// ready path; back-pressure is the stall input, which freezes every ID register
// while the combinational outputs keep following their inputs. A bundle seen
// with en_=1 carries no meaning and never writes state downstream.
module id_stage #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_BE    = 6'h08,
  parameter logic [5:0] OP_BNE   = 6'h09,
  parameter logic [5:0] OP_JR    = 6'h0A,
  parameter logic [5:0] OP_LD    = 6'h0C,
  parameter logic [5:0] OP_ST    = 6'h0D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] if_pc,
  input  logic [31:0] if_insn,
  input  logic        if_en_,
  output logic [4:0]  gpr_rd_addr_0,
  output logic [4:0]  gpr_rd_addr_1,
  input  logic [31:0] gpr_rd_data_0,
  input  logic [31:0] gpr_rd_data_1,
  input  logic        ex_en_,
  input  logic        ex_gpr_we_,
  input  logic        ex_ld_,
  input  logic [4:0]  ex_dst_addr,
  input  logic [31:0] ex_fwd_data,
  input  logic        mem_en_,
  input  logic        mem_gpr_we_,
  input  logic [4:0]  mem_dst_addr,
  input  logic [31:0] mem_fwd_data,
  output logic        br_taken,
  output logic [29:0] br_addr,
  output logic        ld_hazard,
  output logic [29:0] id_pc,
  output logic [31:0] id_insn,
  output logic [31:0] id_ra_data,
  output logic [31:0] id_rb_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dst_addr,
  output logic        id_gpr_we_,
  output logic        id_en_
);

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [4:0]  rc_addr;
  logic [15:0] imm16;

  // Decoded / forwarded values
  logic        ex_fwd_ok;
  logic        mem_fwd_ok;
  logic [31:0] ra_val;
  logic [31:0] rb_val;
  logic        is_be;
  logic        is_bne;
  logic        is_jr;
  logic        is_st;
  logic        no_write;
  logic        br_cond;
  logic [29:0] imm_sext30;
  logic [31:0] imm_sext32;
  logic [4:0]  dst_addr;
  logic        bubble;

  // Registered ID/EX bundle
  logic [29:0] id_pc_q,       id_pc_d;
  logic [31:0] id_insn_q,     id_insn_d;
  logic [31:0] id_ra_data_q,  id_ra_data_d;
  logic [31:0] id_rb_data_q,  id_rb_data_d;
  logic [31:0] id_imm_q,      id_imm_d;
  logic [4:0]  id_dst_addr_q, id_dst_addr_d;
  logic        id_gpr_we_q,   id_gpr_we_d;
  logic        id_en_q,       id_en_d;

  assign op      = if_insn[31:26];
  assign ra_addr = if_insn[25:21];
  assign rb_addr = if_insn[20:16];
  assign rc_addr = if_insn[15:11];
  assign imm16   = if_insn[15:0];

  assign gpr_rd_addr_0 = ra_addr;
  assign gpr_rd_addr_1 = rb_addr;

  // Operand forwarding: a non-load EX result is newest, then MEM, then the GPR file.
  always_comb begin
    ex_fwd_ok  = !ex_en_ && !ex_gpr_we_ && ex_ld_;
    mem_fwd_ok = !mem_en_ && !mem_gpr_we_;
    ra_val     = gpr_rd_data_0;
    rb_val     = gpr_rd_data_1;
    if (ex_fwd_ok && (ex_dst_addr == ra_addr)) begin
      ra_val = ex_fwd_data;
    end else if (mem_fwd_ok && (mem_dst_addr == ra_addr)) begin
      ra_val = mem_fwd_data;
    end
    if (ex_fwd_ok && (ex_dst_addr == rb_addr)) begin
      rb_val = ex_fwd_data;
    end else if (mem_fwd_ok && (mem_dst_addr == rb_addr)) begin
      rb_val = mem_fwd_data;
    end
  end

  // Decode, load-use interlock and zero-cycle branch resolution.
  always_comb begin
    is_be      = (op == OP_BE);
    is_bne     = (op == OP_BNE);
    is_jr      = (op == OP_JR);
    is_st      = (op == OP_ST);
    no_write   = is_be || is_bne || is_jr || is_st;
    imm_sext30 = {{14{imm16[15]}}, imm16};
    imm_sext32 = {{16{imm16[15]}}, imm16};
    dst_addr   = (op == OP_RTYPE) ? rc_addr : rb_addr;

    // A load still in EX has no data yet; any reader must wait one cycle.
    ld_hazard  = !if_en_ && !ex_en_ && !ex_ld_ && !ex_gpr_we_ &&
                 ((ex_dst_addr == ra_addr) || (ex_dst_addr == rb_addr));

    br_cond    = (is_be && (ra_val == rb_val)) ||
                 (is_bne && (ra_val != rb_val)) ||
                 is_jr;
    br_taken   = !if_en_ && !ld_hazard && br_cond;

    br_addr    = 30'd0;
    if (is_be || is_bne) begin
      br_addr = if_pc + 30'd1 + imm_sext30;
    end else if (is_jr) begin
      br_addr = ra_val[31:2];
    end
  end

  // Next bundle: stall holds, flush/hazard/invalid input inserts a bubble.
  always_comb begin
    bubble        = flush || ld_hazard || if_en_;
    id_pc_d       = id_pc_q;
    id_insn_d     = id_insn_q;
    id_ra_data_d  = id_ra_data_q;
    id_rb_data_d  = id_rb_data_q;
    id_imm_d      = id_imm_q;
    id_dst_addr_d = id_dst_addr_q;
    id_gpr_we_d   = id_gpr_we_q;
    id_en_d       = id_en_q;
    if (!stall) begin
      if (bubble) begin
        id_pc_d       = 30'd0;
        id_insn_d     = 32'd0;
        id_ra_data_d  = 32'd0;
        id_rb_data_d  = 32'd0;
        id_imm_d      = 32'd0;
        id_dst_addr_d = 5'd0;
        id_gpr_we_d   = 1'b1;
        id_en_d       = 1'b1;
      end else begin
        id_pc_d       = if_pc;
        id_insn_d     = if_insn;
        id_ra_data_d  = ra_val;
        id_rb_data_d  = rb_val;
        id_imm_d      = imm_sext32;
        id_dst_addr_d = dst_addr;
        id_gpr_we_d   = no_write;
        id_en_d       = 1'b0;
      end
    end
  end

  // ID/EX pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_pc_q       <= 30'd0;
      id_insn_q     <= 32'd0;
      id_ra_data_q  <= 32'd0;
      id_rb_data_q  <= 32'd0;
      id_imm_q      <= 32'd0;
      id_dst_addr_q <= 5'd0;
      id_gpr_we_q   <= 1'b1;
      id_en_q       <= 1'b1;
    end else begin
      id_pc_q       <= id_pc_d;
      id_insn_q     <= id_insn_d;
      id_ra_data_q  <= id_ra_data_d;
      id_rb_data_q  <= id_rb_data_d;
      id_imm_q      <= id_imm_d;
      id_dst_addr_q <= id_dst_addr_d;
      id_gpr_we_q   <= id_gpr_we_d;
      id_en_q       <= id_en_d;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_insn     = id_insn_q;
  assign id_ra_data  = id_ra_data_q;
  assign id_rb_data  = id_rb_data_q;
  assign id_imm      = id_imm_q;
  assign id_dst_addr = id_dst_addr_q;
  assign id_gpr_we_  = id_gpr_we_q;
  assign id_en_      = id_en_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX bundles are queued as each
// instruction is driven and compared one clock later; branch/hazard outputs
// are compared in the same cycle.
module tb_id_stage;

  typedef struct packed {
    logic        en_;
    logic        we_;
    logic [29:0] pc;
    logic [31:0] insn;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] imm;
    logic [4:0]  dst;
  } bundle_t;

  localparam logic [5:0] RT = 6'h00, BE = 6'h08, BNE = 6'h09, JR = 6'h0A,
                         LD = 6'h0C, ST = 6'h0D;

  logic        clk = 1'b0;
  logic        reset, stall, flush, if_en_;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        ex_en_, ex_gpr_we_, ex_ld_;
  logic [4:0]  ex_dst_addr;
  logic [31:0] ex_fwd_data;
  logic        mem_en_, mem_gpr_we_;
  logic [4:0]  mem_dst_addr;
  logic [31:0] mem_fwd_data;
  logic        br_taken, ld_hazard;
  logic [29:0] br_addr, id_pc;
  logic [31:0] id_insn, id_ra_data, id_rb_data, id_imm;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_, id_en_;

  logic [31:0] gpr_mem [32];
  bundle_t     exp_q [$];
  bundle_t     last_b;
  int          n_vec = 0;
  int          n_err = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_insn(if_insn), .if_en_(if_en_),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .ex_en_(ex_en_), .ex_gpr_we_(ex_gpr_we_), .ex_ld_(ex_ld_),
    .ex_dst_addr(ex_dst_addr), .ex_fwd_data(ex_fwd_data),
    .mem_en_(mem_en_), .mem_gpr_we_(mem_gpr_we_),
    .mem_dst_addr(mem_dst_addr), .mem_fwd_data(mem_fwd_data),
    .br_taken(br_taken), .br_addr(br_addr), .ld_hazard(ld_hazard),
    .id_pc(id_pc), .id_insn(id_insn), .id_ra_data(id_ra_data),
    .id_rb_data(id_rb_data), .id_imm(id_imm), .id_dst_addr(id_dst_addr),
    .id_gpr_we_(id_gpr_we_), .id_en_(id_en_)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural GPR file answering the DUT's read addresses
  assign gpr_rd_data_0 = gpr_mem[gpr_rd_addr_0];
  assign gpr_rd_data_1 = gpr_mem[gpr_rd_addr_1];

  function automatic logic [31:0] mk_r(logic [5:0] op, logic [4:0] ra, logic [4:0] rb,
                                       logic [4:0] rc);
    return {op, ra, rb, rc, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(logic [5:0] op, logic [4:0] ra, logic [4:0] rb,
                                       logic [15:0] imm);
    return {op, ra, rb, imm};
  endfunction

  function automatic bundle_t bub();
    bundle_t b;
    b = '0;
    b.en_ = 1'b1;
    b.we_ = 1'b1;
    return b;
  endfunction

  function automatic bundle_t vb(logic we_, logic [29:0] pc, logic [31:0] insn,
                                 logic [31:0] ra, logic [31:0] rb, logic [31:0] imm,
                                 logic [4:0] dst);
    bundle_t b;
    b.en_ = 1'b0; b.we_ = we_; b.pc = pc; b.insn = insn;
    b.ra = ra; b.rb = rb; b.imm = imm; b.dst = dst;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input bundle_t b);
    exp_q.push_back(b);
    last_b = b;
  endtask

  // Same-cycle combinational checks, taken after inputs settle
  task automatic comb(input string tag, input logic haz, input logic tk,
                      input logic [29:0] addr);
    #1;
    chk({tag, ".ld_hazard"}, 32'(ld_hazard), 32'(haz));
    chk({tag, ".br_taken"},  32'(br_taken),  32'(tk));
    chk({tag, ".br_addr"},   {2'b0, br_addr}, {2'b0, addr});
  endtask

  // Clock once, then compare the registered bundle with the queue head
  task automatic tick(input string tag);
    bundle_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed bundle with no expectation queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".en_"},  32'(id_en_),      32'(e.en_));
      chk({tag, ".we_"},  32'(id_gpr_we_),  32'(e.we_));
      chk({tag, ".pc"},   {2'b0, id_pc},    {2'b0, e.pc});
      chk({tag, ".insn"}, id_insn,          e.insn);
      chk({tag, ".ra"},   id_ra_data,       e.ra);
      chk({tag, ".rb"},   id_rb_data,       e.rb);
      chk({tag, ".imm"},  id_imm,           e.imm);
      chk({tag, ".dst"},  32'(id_dst_addr), 32'(e.dst));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr_mem[i] = 32'h1000 + 32'(i);
    gpr_mem[1] = 32'd5;
    gpr_mem[2] = 32'd7;

    // Reset with a valid instruction presented
    reset = 0; stall = 0; flush = 0;
    if_en_ = 0; if_pc = 30'h55; if_insn = mk_r(RT, 1, 2, 3);
    ex_en_ = 1; ex_gpr_we_ = 1; ex_ld_ = 1; ex_dst_addr = 0; ex_fwd_data = 0;
    mem_en_ = 1; mem_gpr_we_ = 1; mem_dst_addr = 0; mem_fwd_data = 0;
    push(bub()); tick("rst0");
    push(bub()); tick("rst1");

    // Plain RTYPE r3 = r1 + r2 from the GPR file
    reset = 1; if_pc = 30'h100; if_insn = mk_r(RT, 1, 2, 3);
    #1;
    chk("add.rd_addr0", 32'(gpr_rd_addr_0), 32'd1);
    chk("add.rd_addr1", 32'(gpr_rd_addr_1), 32'd2);
    comb("add", 0, 0, 30'd0);
    push(vb(0, 30'h100, mk_r(RT, 1, 2, 3), 5, 7, 32'h1800, 3)); tick("add");

    // EX and MEM both write r1: EX wins
    if_pc = 30'h101; if_insn = mk_r(RT, 1, 2, 5);
    ex_en_ = 0; ex_gpr_we_ = 0; ex_dst_addr = 1; ex_fwd_data = 32'hAA;
    mem_en_ = 0; mem_gpr_we_ = 0; mem_dst_addr = 1; mem_fwd_data = 32'hBB;
    comb("fwd_ex", 0, 0, 30'd0);
    push(vb(0, 30'h101, mk_r(RT, 1, 2, 5), 32'hAA, 7, 32'h2800, 5)); tick("fwd_ex");

    // EX invalid: MEM supplies r1
    ex_en_ = 1;
    push(vb(0, 30'h101, mk_r(RT, 1, 2, 5), 32'hBB, 7, 32'h2800, 5)); tick("fwd_mem");

    // EX forwards to rb while MEM forwards to ra
    ex_en_ = 0; ex_dst_addr = 2; ex_fwd_data = 32'hCC;
    push(vb(0, 30'h101, mk_r(RT, 1, 2, 5), 32'hBB, 32'hCC, 32'h2800, 5)); tick("fwd_both");

    // EX write-enable off: no forwarding from EX, MEM off too
    ex_gpr_we_ = 1; mem_en_ = 1;
    push(vb(0, 30'h101, mk_r(RT, 1, 2, 5), 5, 7, 32'h2800, 5)); tick("fwd_none");

    // Load in EX targeting rb of a JR: interlock suppresses the jump
    if_pc = 30'h20; if_insn = mk_i(JR, 6, 4, 16'h0);
    ex_en_ = 0; ex_gpr_we_ = 0; ex_ld_ = 0; ex_dst_addr = 4; ex_fwd_data = 32'hDEAD;
    comb("ldh", 1, 0, 30'h401);
    push(bub()); tick("ldh");

    // Same EX load but IF bundle invalid: no interlock, no redirect
    if_en_ = 1;
    comb("ldh_ifinv", 0, 0, 30'h401);
    push(bub()); tick("ldh_ifinv");

    // EX now a bubble, load data arrives from MEM: JR resolves and loads
    if_en_ = 0; ex_en_ = 1; ex_ld_ = 1; ex_gpr_we_ = 1;
    mem_en_ = 0; mem_gpr_we_ = 0; mem_dst_addr = 4; mem_fwd_data = 32'h1234;
    comb("jr", 0, 1, 30'h401);
    push(vb(1, 30'h20, mk_i(JR, 6, 4, 16'h0), 32'h1006, 32'h1234, 32'h0, 4)); tick("jr");

    // BE taken, negative offset
    mem_en_ = 1;
    if_pc = 30'h10; if_insn = mk_i(BE, 1, 1, 16'hFFFE);
    comb("be", 0, 1, 30'h0F);
    push(vb(1, 30'h10, mk_i(BE, 1, 1, 16'hFFFE), 5, 5, 32'hFFFFFFFE, 1)); tick("be");

    // BNE with equal operands: not taken, target still computed
    if_insn = mk_i(BNE, 1, 1, 16'hFFFE);
    comb("bne_eq", 0, 0, 30'h0F);
    push(vb(1, 30'h10, mk_i(BNE, 1, 1, 16'hFFFE), 5, 5, 32'hFFFFFFFE, 1)); tick("bne_eq");

    // BNE with different operands: taken
    if_pc = 30'h100; if_insn = mk_i(BNE, 1, 2, 16'h0003);
    comb("bne_ne", 0, 1, 30'h104);
    push(vb(1, 30'h100, mk_i(BNE, 1, 2, 16'h0003), 5, 7, 32'h3, 2)); tick("bne_ne");

    // BE at the top of the address space wraps to zero
    if_pc = 30'h3FFFFFFF; if_insn = mk_i(BE, 1, 1, 16'h0);
    comb("be_wrap", 0, 1, 30'h0);
    push(vb(1, 30'h3FFFFFFF, mk_i(BE, 1, 1, 16'h0), 5, 5, 32'h0, 1)); tick("be_wrap");

    // Invalid IF bundle with a BE: no redirect, bubble
    if_en_ = 1; if_pc = 30'h10; if_insn = mk_i(BE, 1, 1, 16'hFFFE);
    comb("be_inv", 0, 0, 30'h0F);
    push(bub()); tick("be_inv");

    // Load a valid ADD
    if_en_ = 0; if_pc = 30'h200; if_insn = mk_r(RT, 2, 1, 9);
    push(vb(0, 30'h200, mk_r(RT, 2, 1, 9), 7, 5, 32'h4800, 9)); tick("add2");

    // Stall beats flush: bundle held while combinational outputs track
    stall = 1; flush = 1; if_pc = 30'h204; if_insn = mk_i(ST, 1, 2, 16'h4);
    #1;
    chk("stall.rd_addr0", 32'(gpr_rd_addr_0), 32'd1);
    push(last_b); tick("stall");

    // Flush alone: bubble
    stall = 0;
    push(bub()); tick("flush");

    // Store: valid bundle, no GPR write
    flush = 0;
    push(vb(1, 30'h204, mk_i(ST, 1, 2, 16'h4), 5, 7, 32'h4, 2)); tick("st");

    // Load: writes rb, sign-extended negative offset
    if_pc = 30'h208; if_insn = mk_i(LD, 3, 8, 16'h8000);
    push(vb(0, 30'h208, mk_i(LD, 3, 8, 16'h8000), 32'h1003, 32'h1008, 32'hFFFF8000, 8));
    tick("ld");

    // Reset mid-stream overrides stall and discards the bundle
    reset = 0; stall = 1; if_pc = 30'h20C; if_insn = mk_r(RT, 1, 2, 3);
    push(bub()); tick("rst_mid");

    // Release reset with nothing valid arriving
    reset = 1; stall = 0; if_en_ = 1;
    push(bub()); tick("idle");

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
